// File: rtl/channel_select.sv
// channel_select: two debounced pushbuttons step a 2-bit VGA channel selector up/down.
module channel_select #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       btn_prev,
  output logic [1:0] channel,
  output logic       channel_changed
);

  localparam int unsigned NUM_BTN  = 2;
  localparam int unsigned BTN_NEXT = 0;
  localparam int unsigned BTN_PREV = 1;
  localparam int unsigned CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] press_c;

  assign btn_raw = {btn_prev, btn_next};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    logic             s1;
    logic             s2;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             differ_c;
    logic             done_c;

    assign differ_c   = (s2 != stable);
    assign done_c     = differ_c && (cnt == CNT_MAX);
    // Only a debounced 0->1 transition counts as a press; releases are silent.
    assign press_c[i] = done_c && s2;

    // Two-flop synchronizer for the asynchronous button level
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
      end else begin
        s1 <= btn_raw[i];
        s2 <= s1;
      end
    end

    // Debounce: the synchronized level must disagree for DEBOUNCE_CYCLES cycles in a row
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stable <= 1'b0;
        cnt    <= '0;
      end else if (!differ_c) begin
        cnt <= '0;
      end else if (done_c) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Channel step on a single press; simultaneous next/prev presses cancel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      channel         <= 2'b00;
      channel_changed <= 1'b0;
    end else begin
      channel_changed <= 1'b0;
      if (press_c[BTN_NEXT] && !press_c[BTN_PREV]) begin
        channel         <= channel + 2'd1;
        channel_changed <= 1'b1;
      end else if (press_c[BTN_PREV] && !press_c[BTN_NEXT]) begin
        channel         <= channel - 2'd1;
        channel_changed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_channel_select.sv
// tb_channel_select: scoreboard bench for channel_select with DEBOUNCE_CYCLES=4.
module tb_channel_select;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_next;
  logic       btn_prev;
  logic [1:0] channel;
  logic       channel_changed;

  int checks   = 0;
  int failures = 0;

  channel_select #(.DEBOUNCE_CYCLES(D)) dut (
    .clk             (clk),
    .rst             (rst),
    .btn_next        (btn_next),
    .btn_prev        (btn_prev),
    .channel         (channel),
    .channel_changed (channel_changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int ch;
    int edge_no;
  } exp_t;

  exp_t exp_q[$];
  int   edge_cnt = 0;
  bit   raw_hist[2][$];   // last raw samples since reset
  bit   win[2][$];        // recent debouncer-visible levels since last acceptance
  bit   m_stable[2];
  bit   m_press[2];
  int   m_ch = 0;
  bit   m_view;
  bit   m_raw;
  bit   m_alldiff;

  // Model: a level is accepted once D consecutive visible samples all differ from the stable level
  always @(posedge clk) begin
    edge_cnt++;
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        raw_hist[b].delete();
        win[b].delete();
        m_stable[b] = 1'b0;
      end
      m_ch = 0;
      exp_q.delete();
    end else begin
      for (int b = 0; b < 2; b++) begin
        m_raw  = (b == 0) ? btn_next : btn_prev;
        // debouncer sees the raw level from two edges earlier (0 right after reset)
        m_view = (raw_hist[b].size() == 2) ? raw_hist[b][0] : 1'b0;
        raw_hist[b].push_back(m_raw);
        if (raw_hist[b].size() > 2) void'(raw_hist[b].pop_front());
        m_press[b] = 1'b0;
        win[b].push_back(m_view);
        if (win[b].size() > D) void'(win[b].pop_front());
        m_alldiff = (win[b].size() == D);
        for (int k = 0; k < win[b].size(); k++)
          if (win[b][k] == m_stable[b]) m_alldiff = 1'b0;
        if (m_alldiff) begin
          m_press[b]  = m_view;
          m_stable[b] = m_view;
          win[b].delete();
        end
      end
      if (m_press[0] && !m_press[1]) begin
        m_ch = (m_ch + 1) % 4;
        exp_q.push_back('{ch: m_ch, edge_no: edge_cnt});
      end else if (m_press[1] && !m_press[0]) begin
        m_ch = (m_ch + 3) % 4;
        exp_q.push_back('{ch: m_ch, edge_no: edge_cnt});
      end
    end
  end

  // ---------------- monitor ----------------
  exp_t mon_e;
  int   prev_ch = 0;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_channel", int'(channel), 0);
      check("rst_changed", int'(channel_changed), 0);
      prev_ch = 0;
    end else if (channel_changed) begin
      check("pulse_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("pulse_channel", int'(channel), mon_e.ch);
        check("pulse_edge", edge_cnt, mon_e.edge_no);
      end
      prev_ch = int'(channel);
    end else begin
      check("channel_steady", int'(channel), prev_ch);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit n, input bit p, input int cycles);
    btn_next = n;
    btn_prev = p;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_imm_channel", int'(channel), 0);
    check("rst_imm_changed", int'(channel_changed), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  int found;

  initial begin
    rst      = 1'b1;
    btn_next = 1'b0;
    btn_prev = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // long hold: one step only
    do_reset();
    drive(1'b1, 1'b0, 50);
    check("hold_once", int'(channel), 1);
    drive(1'b0, 1'b0, 8);

    // wrap forward through 3 -> 0 then back 0 -> 3
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 8);
      drive(1'b0, 1'b0, 8);
    end
    check("four_next", int'(channel), 0);
    drive(1'b0, 1'b1, 8);
    drive(1'b0, 1'b0, 8);
    check("prev_wrap", int'(channel), 3);

    // short glitches never register
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 3);
      drive(1'b0, 1'b0, 3);
    end
    check("glitch_channel", int'(channel), 0);

    // simultaneous presses cancel
    drive(1'b1, 1'b1, 12);
    check("both_channel", int'(channel), 0);
    drive(1'b0, 1'b1, 10);
    check("both_prev_stable", int'(channel), 0);
    drive(1'b0, 1'b0, 10);

    // reset in the middle of a debounce, button held across reset release
    drive(1'b1, 1'b0, 8);
    drive(1'b0, 1'b0, 8);
    check("pre_rst_channel", int'(channel), 1);
    btn_next = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_channel", int'(channel), 0);
    check("mid_rst_changed", int'(channel_changed), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    found = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (found == 0 && channel == 2'd1) found = i;
    end
    check("rst_redebounce_edge", found, D + 2);
    @(negedge clk);
    drive(1'b1, 1'b0, 10);
    drive(1'b0, 1'b0, 8);

    // randomized button activity
    for (int s = 0; s < 80; s++)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 9)));
    drive(1'b0, 1'b0, 20);
    check("no_pending", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
